// File: rtl/squeeze_output_buffer.sv
// squeeze_output_buffer: captures one rate-wide Keccak state slice from the
// permutation controller and streams it out as OUT_W-bit words on a
// valid/ready interface. It tracks the remaining digest length so that
// last_output_block can be reported back to the controller.
// Optional protocol checker: define OUTBUF_PROTOCOL_CHECK_EN.
module squeeze_output_buffer #(
   parameter int RATE_W = 1088,
   parameter int OUT_W  = 64,
   parameter int LEN_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  out_len_words,
   input  logic              output_buffer_we,
   input  logic [RATE_W-1:0] state_in,
   output logic              output_buffer_ready,
   output logic              last_output_block,
   output logic [OUT_W-1:0]  dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_last,
   output logic              busy,
   output logic              err
);

   localparam int WPB    = RATE_W / OUT_W;
   localparam int IDX_W  = $clog2(WPB + 1);
   localparam int BASE_W = $clog2(RATE_W);

   typedef enum logic [1:0] {IDLE, EMPTY, DRAIN} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [LEN_W-1:0]  r_remaining;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  r_blk_words;
   logic [RATE_W-1:0] r_captured;

   logic              w_start_ok;
   logic              w_capture;
   logic              w_xfer;
   logic              w_blk_end;
   logic [BASE_W-1:0] w_base;

   assign w_start_ok = (r_state == IDLE) && start && (out_len_words != '0);
   assign w_capture  = (r_state == EMPTY) && output_buffer_we;
   assign w_xfer     = (r_state == DRAIN) && dout_ready;
   assign w_blk_end  = w_xfer && (r_idx == r_blk_words - 1'b1);
   assign w_base     = BASE_W'(r_idx * OUT_W);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      w_next              = r_state;
      output_buffer_ready = 1'b0;
      last_output_block   = 1'b0;
      dout                = '0;
      dout_valid          = 1'b0;
      dout_last           = 1'b0;
      busy                = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (w_start_ok) w_next = EMPTY;
         end
         EMPTY: begin
            output_buffer_ready = 1'b1;
            last_output_block   = (r_remaining <= LEN_W'(WPB));
            if (output_buffer_we) w_next = DRAIN;
         end
         DRAIN: begin
            dout       = r_captured[w_base +: OUT_W];
            dout_valid = 1'b1;
            dout_last  = (r_remaining == LEN_W'(1));
            if (w_blk_end) w_next = (r_remaining == LEN_W'(1)) ? IDLE : EMPTY;
         end
         default: w_next = IDLE;
      endcase
   end

   // Length, word index and block-size bookkeeping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_remaining <= '0;
         r_idx       <= '0;
         r_blk_words <= '0;
      end else begin
         if (w_start_ok) r_remaining <= out_len_words;
         if (w_capture) begin
            r_blk_words <= (r_remaining < LEN_W'(WPB)) ? IDX_W'(r_remaining) : IDX_W'(WPB);
            r_idx       <= '0;
         end
         if (w_xfer) begin
            r_idx <= r_idx + 1'b1;
            if (r_remaining != '0) r_remaining <= r_remaining - 1'b1;
         end
      end
   end

   // Block capture; only accepted while EMPTY so stray writes leave data intact
   always_ff @(posedge clk) begin
      if (w_capture) r_captured <= state_in;
   end

`ifdef OUTBUF_PROTOCOL_CHECK_EN
   logic             r_err;
   logic             r_hold;
   logic [OUT_W-1:0] r_hold_dout;
   logic             w_viol_we;
   logic             w_viol_start;
   logic             w_viol_stream;

   assign w_viol_we     = output_buffer_we && (r_state != EMPTY);
   assign w_viol_start  = start && busy;
   assign w_viol_stream = r_hold && (!dout_valid || (dout != r_hold_dout));

   // Sticky protocol-error flag and stalled-word snapshot for the stream self-check
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err       <= 1'b0;
         r_hold      <= 1'b0;
         r_hold_dout <= '0;
      end else begin
         r_hold      <= dout_valid && !dout_ready;
         r_hold_dout <= dout;
         if (w_viol_we || w_viol_start || w_viol_stream) r_err <= 1'b1;
`ifndef SYNTHESIS
         if (w_viol_we)     $error("squeeze_output_buffer: output_buffer_we outside EMPTY");
         if (w_viol_start)  $error("squeeze_output_buffer: start while busy");
         if (w_viol_stream) $error("squeeze_output_buffer: dout unstable under backpressure");
`endif
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_squeeze_output_buffer.sv
// tb_squeeze_output_buffer: table-driven cycle vectors for the single-block and
// two-block digests, plus hand-written sequences for backpressure, reset
// mid-drain, writes during drain and zero-length/misuse cases.
module tb_squeeze_output_buffer;

   localparam int RATE_W = 1088;
   localparam int OUT_W  = 64;
   localparam int LEN_W  = 32;
   localparam int WPB    = RATE_W / OUT_W;

`ifdef OUTBUF_PROTOCOL_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [LEN_W-1:0]  out_len_words;
   logic              output_buffer_we;
   logic [RATE_W-1:0] state_in;
   logic              output_buffer_ready;
   logic              last_output_block;
   logic [OUT_W-1:0]  dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              dout_last;
   logic              busy;
   logic              err;

   int n_tests = 0;
   int n_fail  = 0;

   squeeze_output_buffer #(.RATE_W(RATE_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .start               (start),
      .out_len_words       (out_len_words),
      .output_buffer_we    (output_buffer_we),
      .state_in            (state_in),
      .output_buffer_ready (output_buffer_ready),
      .last_output_block   (last_output_block),
      .dout                (dout),
      .dout_valid          (dout_valid),
      .dout_ready          (dout_ready),
      .dout_last           (dout_last),
      .busy                (busy),
      .err                 (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic        rst_n;
      logic        start;
      int          len;
      logic        we;
      int          base;
      logic        rdy;
      logic        e_obr;
      logic        e_lob;
      logic        e_val;
      logic        e_last;
      logic        e_busy;
      logic [63:0] e_dout;
   } vec_t;

   vec_t vt[$];

   function automatic logic [RATE_W-1:0] mk_state(input int base);
      logic [RATE_W-1:0] s;
      s = '0;
      for (int i = 0; i < WPB; i++) s[i*OUT_W +: OUT_W] = OUT_W'(base + i);
      return s;
   endfunction

   function automatic vec_t mkv(input logic r, input logic st, input int len, input logic we,
                                input int base, input logic rdy, input logic obr, input logic lob,
                                input logic val, input logic last, input logic bsy, input int d);
      vec_t v;
      v.rst_n = r;   v.start = st; v.len = len; v.we = we; v.base = base; v.rdy = rdy;
      v.e_obr = obr; v.e_lob = lob; v.e_val = val; v.e_last = last; v.e_busy = bsy;
      v.e_dout = 64'(d);
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst_n = 1'b1; start = 1'b0; out_len_words = '0; output_buffer_we = 1'b0;
      state_in = '0; dout_ready = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic do_start(input int len);
      start = 1'b1; out_len_words = LEN_W'(len);
      cyc();
      start = 1'b0; out_len_words = '0;
   endtask

   task automatic do_write(input int base);
      output_buffer_we = 1'b1; state_in = mk_state(base);
      cyc();
      output_buffer_we = 1'b0; state_in = '0;
   endtask

   int n;
   logic prev_stall;
   logic [OUT_W-1:0] prev_dout;

   initial begin
      idle_inputs();

      // ---- vector table ----
      // reset rows
      vt.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mkv(0, 1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      // single block of 17 words
      vt.push_back(mkv(1, 1, 17, 0, 0, 1, 1, 1, 0, 0, 1, 0));
      vt.push_back(mkv(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0));
      for (int i = 1; i < 17; i++)
         vt.push_back(mkv(1, 0, 0, 0, 0, 1, 0, 0, 1, (i == 16), 1, i));
      vt.push_back(mkv(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      // 20 words: full block then 3-word partial block
      vt.push_back(mkv(1, 1, 20, 0, 0, 1, 1, 0, 0, 0, 1, 0));
      vt.push_back(mkv(1, 0, 0, 1, 100, 1, 0, 0, 1, 0, 1, 100));
      for (int i = 1; i < 17; i++)
         vt.push_back(mkv(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 100 + i));
      vt.push_back(mkv(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0));
      vt.push_back(mkv(1, 0, 0, 1, 200, 1, 0, 0, 1, 0, 1, 200));
      vt.push_back(mkv(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 201));
      vt.push_back(mkv(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 202));
      vt.push_back(mkv(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

      for (int k = 0; k < vt.size(); k++) begin
         rst_n = vt[k].rst_n; start = vt[k].start; out_len_words = LEN_W'(vt[k].len);
         output_buffer_we = vt[k].we; state_in = mk_state(vt[k].base); dout_ready = vt[k].rdy;
         cyc();
         chk($sformatf("v%0d.obuf_ready", k), 64'(output_buffer_ready), 64'(vt[k].e_obr));
         chk($sformatf("v%0d.last_blk", k), 64'(last_output_block), 64'(vt[k].e_lob));
         chk($sformatf("v%0d.dout_valid", k), 64'(dout_valid), 64'(vt[k].e_val));
         chk($sformatf("v%0d.dout_last", k), 64'(dout_last), 64'(vt[k].e_last));
         chk($sformatf("v%0d.busy", k), 64'(busy), 64'(vt[k].e_busy));
         chk($sformatf("v%0d.err", k), 64'(err), 64'(0));
         if (vt[k].e_val || !vt[k].rst_n) chk($sformatf("v%0d.dout", k), 64'(dout), vt[k].e_dout);
      end
      idle_inputs();

      // ---- backpressure: 5 words, ready pattern 1,0,0 repeating ----
      do_start(5);
      do_write(300);
      n = 0;
      prev_stall = 1'b0;
      prev_dout = '0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         dout_ready = (c % 3 == 0);
         chk("bp.valid", 64'(dout_valid), 64'(1));
         if (prev_stall) chk("bp.hold", 64'(dout), 64'(prev_dout));
         if (dout_ready) begin
            chk("bp.word", 64'(dout), 64'(300 + n));
            chk("bp.last", 64'(dout_last), 64'(n == 4));
            n++;
         end
         prev_stall = !dout_ready;
         prev_dout = dout;
         cyc();
      end
      dout_ready = 1'b1;
      chk("bp.count", 64'(n), 64'(5));
      chk("bp.busy_done", 64'(busy), 64'(0));
      chk("bp.valid_done", 64'(dout_valid), 64'(0));

      // ---- reset at word 4 of 17 ----
      do_start(17);
      do_write(400);
      for (int i = 0; i < 4; i++) cyc();
      chk("rst.word4", 64'(dout), 64'(404));
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("rst.valid", 64'(dout_valid), 64'(0));
      chk("rst.busy", 64'(busy), 64'(0));
      chk("rst.dout", 64'(dout), 64'(0));
      do_start(3);
      chk("rst.lob", 64'(last_output_block), 64'(1));
      do_write(500);
      for (int i = 0; i < 3; i++) begin
         chk("rst.new_word", 64'(dout), 64'(500 + i));
         chk("rst.new_last", 64'(dout_last), 64'(i == 2));
         cyc();
      end
      chk("rst.new_idle", 64'(busy), 64'(0));

      // ---- write during drain ----
      do_start(4);
      do_write(600);
      for (int i = 0; i < 4; i++) begin
         chk("wdr.word", 64'(dout), 64'(600 + i));
         if (i == 1) begin
            output_buffer_we = 1'b1; state_in = mk_state(700);
         end
         cyc();
         output_buffer_we = 1'b0; state_in = '0;
      end
      chk("wdr.idle", 64'(busy), 64'(0));
      chk("wdr.err", 64'(err), 64'(EXP_ERR));

      // ---- zero length start and stray write in IDLE ----
      do_reset();
      chk("zl.err_reset", 64'(err), 64'(0));
      do_start(0);
      chk("zl.busy", 64'(busy), 64'(0));
      chk("zl.obr", 64'(output_buffer_ready), 64'(0));
      do_write(800);
      chk("zl.busy2", 64'(busy), 64'(0));
      chk("zl.valid", 64'(dout_valid), 64'(0));
      chk("zl.err", 64'(err), 64'(EXP_ERR));
      cyc();
      chk("zl.valid2", 64'(dout_valid), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
